// File: rtl/dma_grant_cmd_dispatcher.sv
// Grant-to-command dispatcher: snapshots the granted channel's descriptor into a show-ahead
// command FIFO and acknowledges the arbiter. Optional one-hot grant check: DMA_DISPATCH_ONEHOT_CHK_EN.
module dma_grant_cmd_dispatcher #(
    parameter int NO_OF_CHANNELS = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int BCNT_WIDTH     = 23,
    parameter int FIFO_DEPTH     = 4,
    parameter int CHID_WIDTH     = 2
) (
    input  logic                                   clock,
    input  logic                                   resetn,
    input  logic [NO_OF_CHANNELS-1:0]              grant,
    input  logic [NO_OF_CHANNELS*ADDR_WIDTH-1:0]   srcAddr,
    input  logic [NO_OF_CHANNELS*ADDR_WIDTH-1:0]   dstAddr,
    input  logic [NO_OF_CHANNELS*BCNT_WIDTH-1:0]   byteCnt,
    output logic                                   grantAck,
    output logic [NO_OF_CHANNELS-1:0]              chanAccept,
    output logic [NO_OF_CHANNELS-1:0]              chanZeroLen,
    output logic                                   cmdValid,
    input  logic                                   cmdReady,
    output logic [CHID_WIDTH-1:0]                  cmdChId,
    output logic [ADDR_WIDTH-1:0]                  cmdSrc,
    output logic [ADDR_WIDTH-1:0]                  cmdDst,
    output logic [BCNT_WIDTH-1:0]                  cmdBcnt,
    output logic [$clog2(FIFO_DEPTH):0]            fifoLevel,
    output logic                                   grantErr,
    output logic                                   dbgState
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int CMD_W = CHID_WIDTH + 2 * ADDR_WIDTH + BCNT_WIDTH;
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

    typedef enum logic {IDLE = 1'b0, ACK = 1'b1} state_t;

    state_t                    state;
    logic [NO_OF_CHANNELS-1:0] selOneHot;
    logic [CHID_WIDTH-1:0]     selId;
    logic [ADDR_WIDTH-1:0]     selSrc;
    logic [ADDR_WIDTH-1:0]     selDst;
    logic [BCNT_WIDTH-1:0]     selBcnt;
    logic                      capture;
    logic                      push;
    logic                      pop;
    logic [CMD_W-1:0]          mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wrPtr;
    logic [PTR_W-1:0]          rdPtr;

    // Lowest set bit wins; with a legal one-hot grant this is simply the granted channel.
    always_comb begin
        selId     = '0;
        selOneHot = '0;
        for (int i = NO_OF_CHANNELS - 1; i >= 0; i--) begin
            if (grant[i]) begin
                selId        = CHID_WIDTH'(i);
                selOneHot    = '0;
                selOneHot[i] = 1'b1;
            end
        end
    end

    assign selSrc  = srcAddr[int'(selId)*ADDR_WIDTH +: ADDR_WIDTH];
    assign selDst  = dstAddr[int'(selId)*ADDR_WIDTH +: ADDR_WIDTH];
    assign selBcnt = byteCnt[int'(selId)*BCNT_WIDTH +: BCNT_WIDTH];

`ifdef DMA_DISPATCH_ONEHOT_CHK_EN
    logic grantOneHot;
    assign grantOneHot = (grant != '0) && ((grant & (grant - 1'b1)) == '0);
    assign capture     = (state == IDLE) && grantOneHot && (fifoLevel < DEPTH_L);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            grantErr <= 1'b0;
        end else if ((state == IDLE) && (grant != '0) && !grantOneHot) begin
            grantErr <= 1'b1;
        end
    end
`else
    assign capture  = (state == IDLE) && (grant != '0) && (fifoLevel < DEPTH_L);
    assign grantErr = 1'b0;
`endif

    // Full check uses the pre-pop level, so a same-cycle pop never lets a capture into a full FIFO.
    assign push        = capture && (selBcnt != '0);
    assign pop         = cmdValid && cmdReady;
    assign chanAccept  = capture ? selOneHot : '0;
    assign chanZeroLen = (capture && (selBcnt == '0)) ? selOneHot : '0;
    assign dbgState    = state;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            grantAck <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        state    <= ACK;
                        grantAck <= 1'b1;
                    end else begin
                        grantAck <= 1'b0;
                    end
                end
                ACK: begin
                    state    <= IDLE;
                    grantAck <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    grantAck <= 1'b0;
                end
            endcase
        end
    end

    // Command stream: the engine takes the head when cmdValid && cmdReady on a rising edge;
    // cmdValid stays high and the head stays stable until that pop, and cmdReady alone never moves anything.
    assign cmdValid = (fifoLevel != '0);
    assign {cmdChId, cmdSrc, cmdDst, cmdBcnt} = mem[rdPtr];

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoLevel <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + 1'b1;
            if (pop)  rdPtr <= rdPtr + 1'b1;
            case ({push, pop})
                2'b10:   fifoLevel <= fifoLevel + 1'b1;
                2'b01:   fifoLevel <= fifoLevel - 1'b1;
                default: fifoLevel <= fifoLevel;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= {selId, selSrc, selDst, selBcnt};
    end

endmodule
